// File: rtl/arp_reply_gen.sv
// arp_reply_gen
//   Egress ARP responder. A reply descriptor (requester MAC/IP plus the
//   matched interface index) is turned into a complete ARP reply frame
//   (oper=2) and streamed out on an AXI-Stream master, answering on behalf
//   of the matched virtual interface.
//
//   Build option: define ARP_VLAN_TAG_EN to insert an 802.1Q tag
//   (0x8100 + vlan_tags[id]) at bytes 12-15. Without it the frame is
//   untagged and vlan_tags is ignored.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   req_valid/ready    descriptor handshake
//   req_sha, req_spa   requester MAC / IP (reply destination)
//   req_id             matched interface index
//   mac_addresses      per-interface MAC, entry i at [48*i +: 48]
//   ip4_addresses      per-interface IPv4, entry i at [32*i +: 32]
//   vlan_tags          per-interface TCI, entry i at [16*i +: 16]
//   axis_out_*         frame stream, byte 0 in tdata[7:0]
//   dbg_state          current FSM state (0 = IDLE, 1 = SEND)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The descriptor side accepts only in IDLE. On the stream side
// tvalid stays high from the first beat to the tlast transfer, and the beat
// payload only changes on a transfer.
module arp_reply_gen #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int REPLY_DEST      = 0,
  parameter int PAD_TO_MIN      = 1,
  localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH,
  localparam int EFF_ID_WIDTH   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int EFF_DEST_WIDTH = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int KEEP_W         = AXIS_BUS_WIDTH / 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [47:0]                   req_sha,
  input  logic [31:0]                   req_spa,
  input  logic [EFF_ID_WIDTH-1:0]       req_id,
  input  logic [48*NUM_AXIS_ID-1:0]     mac_addresses,
  input  logic [32*NUM_AXIS_ID-1:0]     ip4_addresses,
  input  logic [16*NUM_AXIS_ID-1:0]     vlan_tags,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic [EFF_ID_WIDTH-1:0]       axis_out_tid,
  output logic [EFF_DEST_WIDTH-1:0]     axis_out_tdest,
  output logic [KEEP_W-1:0]             axis_out_tkeep,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic                          dbg_state
);

`ifdef ARP_VLAN_TAG_EN
  localparam int TAG_BYTES = 4;
`else
  localparam int TAG_BYTES = 0;
`endif
  localparam int HDR_BYTES   = 42 + TAG_BYTES;
  localparam int MIN_BYTES   = 60 + TAG_BYTES;
  localparam int FRAME_BYTES = (PAD_TO_MIN != 0) ? MIN_BYTES : HDR_BYTES;
  localparam int BEATS       = (FRAME_BYTES + KEEP_W - 1) / KEEP_W;
  localparam int REM         = FRAME_BYTES % KEEP_W;
  localparam int BUF_W       = BEATS * AXIS_BUS_WIDTH;
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [KEEP_W-1:0] ALL_KEEP   = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] LAST_KEEP  = (REM == 0) ? ALL_KEEP : (ALL_KEEP >> (KEEP_W - REM));
  localparam logic              FIRST_LAST = (BEATS == 1);
  localparam logic [KEEP_W-1:0] FIRST_KEEP = FIRST_LAST ? LAST_KEEP : ALL_KEEP;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [BUF_W-1:0]             frame_q;
  logic [AXIS_BUS_WIDTH-1:0]    tdata_q;
  logic [KEEP_W-1:0]            tkeep_q;
  logic                         tlast_q;
  logic                         tvalid_q;
  logic [EFF_ID_WIDTH-1:0]      tid_q;

  // Table entry for the incoming descriptor, looked up combinationally so the
  // whole frame can be captured in the accept cycle.
  logic [47:0]                  sel_mac;
  logic [31:0]                  sel_ip;
  logic [HDR_BYTES*8-1:0]       hdr;
  logic [BUF_W-1:0]             frame_new;
  logic [CNT_W-1:0]             nxt_cnt;

  assign sel_mac = mac_addresses[req_id*48 +: 48];
  assign sel_ip  = ip4_addresses[req_id*32 +: 32];

`ifdef ARP_VLAN_TAG_EN
  logic [15:0] sel_tci;
  assign sel_tci = vlan_tags[req_id*16 +: 16];
  assign hdr = {req_sha, sel_mac, 16'h8100, sel_tci, 16'h0806, 16'h0001, 16'h0800,
                8'h06, 8'h04, 16'h0002, sel_mac, sel_ip, req_sha, req_spa};
`else
  logic unused_vlan_tags;
  assign unused_vlan_tags = ^vlan_tags;
  assign hdr = {req_sha, sel_mac, 16'h0806, 16'h0001, 16'h0800,
                8'h06, 8'h04, 16'h0002, sel_mac, sel_ip, req_sha, req_spa};
`endif

  // hdr is written in network order (byte 0 in the MSBs); the stream wants
  // byte 0 in the LSBs, so reverse byte order. Pad bytes stay zero.
  always_comb begin
    frame_new = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      frame_new[8*i +: 8] = hdr[8*(HDR_BYTES-1-i) +: 8];
    end
  end

  assign nxt_cnt = cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      frame_q  <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tid_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            frame_q  <= frame_new;
            tdata_q  <= frame_new[AXIS_BUS_WIDTH-1:0];
            tkeep_q  <= FIRST_KEEP;
            tlast_q  <= FIRST_LAST;
            tid_q    <= req_id;
            tvalid_q <= 1'b1;
            cnt      <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (axis_out_tready) begin
            if (tlast_q) begin
              // Frame done; the IDLE cycle that follows is the inter-frame bubble.
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              cnt      <= '0;
              state    <= S_IDLE;
            end else begin
              cnt     <= nxt_cnt;
              tdata_q <= frame_q[nxt_cnt*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
              tkeep_q <= (nxt_cnt == LAST_CNT) ? LAST_KEEP : ALL_KEEP;
              tlast_q <= (nxt_cnt == LAST_CNT);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = (state == S_IDLE) & aresetn;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tkeep  = tkeep_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = EFF_DEST_WIDTH'(REPLY_DEST);
  assign dbg_state       = state;

endmodule

// File: tb/tb_arp_reply_gen.sv
// Directed bench for arp_reply_gen: one unpadded instance (index 0) and one
// padded instance (index 1) share the descriptor and table inputs.
module tb_arp_reply_gen;

  logic        aclk;
  logic        aresetn;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [47:0] req_sha;
  logic [31:0] req_spa;
  logic [3:0]  req_id;
  logic [48*16-1:0] mac_tbl;
  logic [32*16-1:0] ip_tbl;
  logic [16*16-1:0] vlan_tbl;
  logic [63:0] tdata  [2];
  logic [3:0]  tid    [2];
  logic [3:0]  tdest  [2];
  logic [7:0]  tkeep  [2];
  logic        tlast  [2];
  logic        tvalid [2];
  logic        tready [2];
  logic        dbg    [2];

  logic [63:0] exp_q[$];
  logic [63:0] got [8];
  int n_checks = 0;
  int n_pass   = 0;

`ifdef ARP_VLAN_TAG_EN
  localparam int OFF = 4;
`else
  localparam int OFF = 0;
`endif

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  arp_reply_gen #(.PAD_TO_MIN(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_sha(req_sha), .req_spa(req_spa), .req_id(req_id),
    .mac_addresses(mac_tbl), .ip4_addresses(ip_tbl), .vlan_tags(vlan_tbl),
    .axis_out_tdata(tdata[0]), .axis_out_tid(tid[0]), .axis_out_tdest(tdest[0]),
    .axis_out_tkeep(tkeep[0]), .axis_out_tlast(tlast[0]), .axis_out_tvalid(tvalid[0]),
    .axis_out_tready(tready[0]), .dbg_state(dbg[0])
  );

  arp_reply_gen #(.PAD_TO_MIN(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_sha(req_sha), .req_spa(req_spa), .req_id(req_id),
    .mac_addresses(mac_tbl), .ip4_addresses(ip_tbl), .vlan_tags(vlan_tbl),
    .axis_out_tdata(tdata[1]), .axis_out_tid(tid[1]), .axis_out_tdest(tdest[1]),
    .axis_out_tkeep(tkeep[1]), .axis_out_tlast(tlast[1]), .axis_out_tvalid(tvalid[1]),
    .axis_out_tready(tready[1]), .dbg_state(dbg[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // scoreboard model: expected frame from the current descriptor and tables
  task automatic push_frame(input int pad);
    logic [7:0]  b [64];
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] tci;
    logic [63:0] w;
    int len, nb;
    mac = mac_tbl[req_id*48 +: 48];
    ip  = ip_tbl[req_id*32 +: 32];
    tci = vlan_tbl[req_id*16 +: 16];
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]          = req_sha[47-8*i -: 8];
      b[6+i]        = mac[47-8*i -: 8];
      b[22+OFF+i]   = mac[47-8*i -: 8];
      b[32+OFF+i]   = req_sha[47-8*i -: 8];
    end
    if (OFF == 4) begin
      b[12] = 8'h81; b[13] = 8'h00; b[14] = tci[15:8]; b[15] = tci[7:0];
    end
    b[12+OFF] = 8'h08; b[13+OFF] = 8'h06; b[14+OFF] = 8'h00; b[15+OFF] = 8'h01;
    b[16+OFF] = 8'h08; b[17+OFF] = 8'h00; b[18+OFF] = 8'h06; b[19+OFF] = 8'h04;
    b[20+OFF] = 8'h00; b[21+OFF] = 8'h02;
    for (int i = 0; i < 4; i++) begin
      b[28+OFF+i] = ip[31-8*i -: 8];
      b[38+OFF+i] = req_spa[31-8*i -: 8];
    end
    len = (pad != 0) ? 60 + OFF : 42 + OFF;
    nb  = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = b[8*k+j];
      exp_q.push_back(w);
    end
  endtask

  // driver: present a descriptor at the current negedge, wait for accept
  task automatic issue(input int d);
    int n;
    n = 0;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) check("req_timeout", 64'd0, 64'd1);
    @(negedge aclk);
    req_valid[d] = 1'b0;
    check("first_beat_latency", 64'(tvalid[d]), 64'd1);
  endtask

  // collect one frame, optionally stalling with tready = 1,0,1,0...
  task automatic recv(input int d, input bit stall, input logic [7:0] lk, input logic [3:0] etid);
    int nb, beats, cyc;
    logic [63:0] held, w;
    bit stalled;
    nb = exp_q.size();
    beats = 0; cyc = 0; stalled = 0; held = '0;
    while (beats < nb && cyc < 100) begin
      tready[d] = stall ? (cyc % 2 == 0) : 1'b1;
      check("tvalid_mid_frame", 64'(tvalid[d]), 64'd1);
      if (stalled) check("stall_hold", tdata[d], held);
      if (tready[d]) begin
        w = exp_q.pop_front();
        check($sformatf("tdata_b%0d", beats), tdata[d], w);
        check($sformatf("tkeep_b%0d", beats), 64'(tkeep[d]), (beats == nb-1) ? 64'(lk) : 64'hFF);
        check($sformatf("tlast_b%0d", beats), 64'(tlast[d]), 64'(beats == nb-1));
        check("tid", 64'(tid[d]), 64'(etid));
        got[beats] = tdata[d];
        beats++;
        stalled = 0;
      end else begin
        held = tdata[d];
        stalled = 1;
      end
      @(negedge aclk);
      cyc++;
    end
    tready[d] = 1'b1;
    check("beat_count", 64'(beats), 64'(nb));
    check("bubble_tvalid", 64'(tvalid[d]), 64'd0);
    check("ready_after_last", 64'(req_ready[d]), 64'd1);
  endtask

  logic [7:0] lk0, lk1;

  initial begin
    lk0 = (OFF == 4) ? 8'h3F : 8'h03;
    lk1 = (OFF == 4) ? 8'hFF : 8'h0F;
    for (int i = 0; i < 16; i++) begin
      mac_tbl[i*48 +: 48]  = 48'h0200_0000_0000 | 48'(i);
      ip_tbl[i*32 +: 32]   = 32'h0A00_0000 | 32'(i);
      vlan_tbl[i*16 +: 16] = 16'h0061 + 16'(i);
    end
    aresetn = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tready[0] = 1'b1; tready[1] = 1'b1;
    req_sha = 48'h0011_2233_4455;
    req_spa = 32'h0A00_0009;
    req_id  = 4'd3;

    // reset values
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(tvalid[0]), 64'd0);
    check("rst_tlast", 64'(tlast[0]), 64'd0);
    check("rst_tkeep", 64'(tkeep[0]), 64'd0);
    check("rst_tdata", tdata[0], 64'd0);
    check("rst_tid", 64'(tid[0]), 64'd0);
    check("rst_req_ready", 64'(req_ready[0]), 64'd0);
    check("rst_tvalid_pad", 64'(tvalid[1]), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_req_ready", 64'(req_ready[0]), 64'd1);
    check("tdest", 64'(tdest[0]), 64'd0);

    // 1: unpadded frame, id 3
    push_frame(0);
    issue(0);
    check("dbg_send", 64'(dbg[0]), 64'd1);
    recv(0, 0, lk0, 4'd3);
`ifdef ARP_VLAN_TAG_EN
    check("vlan_bytes_12_15", 64'(got[1][63:32]), 64'h6400_0081);
    check("vlan_etype_16_17", 64'(got[2][15:0]), 64'h0608);
`else
    check("etype_bytes_12_13", 64'(got[1][47:32]), 64'h0608);
    check("tpa_bytes_38_39", 64'(got[4][63:48]), 64'h000A);
    check("tpa_bytes_40_41", 64'(got[5][15:0]), 64'h0900);
`endif

    // 2: padded frame
    push_frame(1);
    issue(1);
    recv(1, 0, lk1, 4'd3);
`ifndef ARP_VLAN_TAG_EN
    check("pad_beat6", got[6], 64'd0);
    check("pad_beat7", got[7], 64'd0);
`endif

    // 3: tready toggling
    push_frame(0);
    issue(0);
    recv(0, 1, lk0, 4'd3);

    // 4: back-to-back descriptors, table changed mid-frame
    req_id  = 4'd5;
    req_sha = 48'hA0B1_C2D3_E4F5;
    req_spa = 32'hC0A8_0001;
    push_frame(0);
    req_valid[0] = 1'b1;
    while (!req_ready[0]) @(negedge aclk);
    @(negedge aclk);
    check("b2b_first_tvalid", 64'(tvalid[0]), 64'd1);
    req_sha = 48'h0A0B_0C0D_0E0F;
    req_spa = 32'hC0A8_0002;
    ip_tbl[5*32 +: 32] = 32'hC0A8_0105;
    recv(0, 0, lk0, 4'd5);
    push_frame(0);
    @(negedge aclk);
    check("b2b_second_accept", 64'(tvalid[0]), 64'd1);
    req_valid[0] = 1'b0;
    recv(0, 0, lk0, 4'd5);

    // 5: reset during the third beat, then a clean frame
    req_id  = 4'd3;
    req_sha = 48'h0011_2233_4455;
    req_spa = 32'h0A00_0009;
    push_frame(0);
    issue(0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("abort_tvalid", 64'(tvalid[0]), 64'd0);
    check("abort_tlast", 64'(tlast[0]), 64'd0);
    check("abort_req_ready", 64'(req_ready[0]), 64'd0);
    aresetn = 1'b1;
    exp_q.delete();
    push_frame(0);
    issue(0);
    recv(0, 0, lk0, 4'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
